// File: rtl/uart_alu_interface_pkg.sv
// Shared definitions for the UART-to-ALU command decoder: FSM states,
// ALU opcodes and error codes.
package uart_alu_interface_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_A    = 3'd0,
    ST_WAIT_B    = 3'd1,
    ST_WAIT_OP   = 3'd2,
    ST_EXEC      = 3'd3,
    ST_SEND      = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_e;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/uart_alu_interface_alu_core.sv
// Combinational ALU: A, B, opcode -> result. Unknown opcodes yield zero.
module alu_core
  import uart_alu_interface_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 6
) (
  input  logic [DATA_WIDTH-1:0]   i_a,
  input  logic [DATA_WIDTH-1:0]   i_b,
  input  logic [OPCODE_WIDTH-1:0] i_op,
  output logic [DATA_WIDTH-1:0]   o_result
);

  // Shift amounts at or beyond the operand width saturate explicitly.
  localparam logic [DATA_WIDTH-1:0] SHIFT_LIMIT = DATA_WIDTH'(DATA_WIDTH);

  // Opcode decode and result selection
  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD: o_result = i_a + i_b;
      OP_SUB: o_result = i_a - i_b;
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_NOR: o_result = ~(i_a | i_b);
      OP_SRA: begin
        if (i_b >= SHIFT_LIMIT) o_result = {DATA_WIDTH{i_a[DATA_WIDTH-1]}};
        else                    o_result = $signed(i_a) >>> i_b;
      end
      OP_SRL: begin
        if (i_b >= SHIFT_LIMIT) o_result = '0;
        else                    o_result = i_a >> i_b;
      end
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/uart_alu_interface.sv
// Command decoder between UART rx/tx and the ALU. Collects A, B and opcode
// bytes, checks even parity, launches the result to the transmitter and
// waits for completion. Bad parity or inter-byte stalls drop the frame.
//
// state        | meaning
// WAIT_A       | idle, waiting for operand A
// WAIT_B       | A latched, waiting for operand B (timeout armed)
// WAIT_OP      | B latched, waiting for opcode (timeout armed)
// EXEC         | register ALU result into the tx output
// SEND         | one-cycle transmit start pulse
// WAIT_DONE    | waiting for the transmitter to finish
module uart_alu_interface
  import uart_alu_interface_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int OPCODE_WIDTH   = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_parity,
  input  logic                  i_tx_done,
  output logic                  o_tx_signal,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_parity,
  output logic                  o_busy,
  output logic                  o_error,
  output logic [1:0]            o_error_code
);

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic                    rx_done_q, rx_done_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [OPCODE_WIDTH-1:0] op_q, op_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    tx_signal_q, tx_signal_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_parity_q, tx_parity_d;
  logic                    busy_q, busy_d;
  logic                    error_q, error_d;
  logic [1:0]              error_code_q, error_code_d;

  logic                    rx_edge;
  logic                    parity_ok;
  logic                    timeout_hit;
  logic [DATA_WIDTH-1:0]   alu_result;

  alu_core #(
    .DATA_WIDTH   (DATA_WIDTH),
    .OPCODE_WIDTH (OPCODE_WIDTH)
  ) u_alu_core (
    .i_a      (a_q),
    .i_b      (b_q),
    .i_op     (op_q),
    .o_result (alu_result)
  );

  assign rx_edge     = i_rx_done & ~rx_done_q;
  assign parity_ok   = (i_rx_parity == ^i_rx_data);
  assign timeout_hit = (cnt_q == CNT_LAST);

  // State and output registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_WAIT_A;
      rx_done_q    <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      cnt_q        <= '0;
      tx_signal_q  <= 1'b0;
      tx_data_q    <= '0;
      tx_parity_q  <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      error_code_q <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      rx_done_q    <= rx_done_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      tx_signal_q  <= tx_signal_d;
      tx_data_q    <= tx_data_d;
      tx_parity_q  <= tx_parity_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
      error_code_q <= error_code_d;
    end
  end

  // Next-state, byte capture, timeout and output decode
  always_comb begin
    state_d      = state_q;
    rx_done_d    = i_rx_done;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    cnt_d        = '0;
    tx_signal_d  = 1'b0;
    tx_data_d    = tx_data_q;
    tx_parity_d  = tx_parity_q;
    error_d      = 1'b0;
    error_code_d = error_code_q;

    case (state_q)
      ST_WAIT_A, ST_WAIT_B, ST_WAIT_OP: begin
        if (rx_edge && !parity_ok) begin
          error_d      = 1'b1;
          error_code_d = ERR_PARITY;
          state_d      = ST_WAIT_A;
          a_d          = '0;
          b_d          = '0;
          op_d         = '0;
        end else if (rx_edge) begin
          // A byte arriving on the terminal count still counts as in time.
          case (state_q)
            ST_WAIT_A: begin
              a_d     = i_rx_data;
              state_d = ST_WAIT_B;
            end
            ST_WAIT_B: begin
              b_d     = i_rx_data;
              state_d = ST_WAIT_OP;
            end
            default: begin
              op_d    = i_rx_data[OPCODE_WIDTH-1:0];
              state_d = ST_EXEC;
            end
          endcase
        end else if (state_q != ST_WAIT_A) begin
          if (timeout_hit) begin
            error_d      = 1'b1;
            error_code_d = ERR_TIMEOUT;
            state_d      = ST_WAIT_A;
            a_d          = '0;
            b_d          = '0;
            op_d         = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_EXEC: begin
        tx_data_d   = alu_result;
        tx_parity_d = ^alu_result;
        tx_signal_d = 1'b1;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i_tx_done) state_d = ST_WAIT_A;
      end
      default: begin
        state_d = ST_WAIT_A;
      end
    endcase

    busy_d = (state_d != ST_WAIT_A);
  end

  assign o_tx_signal  = tx_signal_q;
  assign o_tx_data    = tx_data_q;
  assign o_tx_parity  = tx_parity_q;
  assign o_busy       = busy_q;
  assign o_error      = error_q;
  assign o_error_code = error_code_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for uart_alu_interface: table of full frames plus
// directed sequences for parity error, timeout, ignored bytes and reset.
module tb_uart_alu_interface;

  logic       clk;
  logic       rst;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       rx_parity;
  logic       tx_done;
  logic       tx_signal;
  logic [7:0] tx_data;
  logic       tx_parity;
  logic       busy;
  logic       error;
  logic [1:0] error_code;

  int checks = 0;
  int errors = 0;
  int tx_pulses = 0;
  int err_pulses = 0;

  uart_alu_interface #(
    .DATA_WIDTH     (8),
    .OPCODE_WIDTH   (6),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_rx_done    (rx_done),
    .i_rx_data    (rx_data),
    .i_rx_parity  (rx_parity),
    .i_tx_done    (tx_done),
    .o_tx_signal  (tx_signal),
    .o_tx_data    (tx_data),
    .o_tx_parity  (tx_parity),
    .o_busy       (busy),
    .o_error      (error),
    .o_error_code (error_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_signal) tx_pulses++;
    if (error)     err_pulses++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] res;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One idle cycle (so the edge detector sees low), then one accept edge.
  task automatic send_byte(input logic [7:0] d, input logic bad);
    @(posedge clk); #1;
    rx_data   = d;
    rx_parity = (^d) ^ bad;
    rx_done   = 1'b1;
    @(posedge clk); #1;
    rx_done   = 1'b0;
  endtask

  // Called right after the opcode accept edge.
  task automatic finish_frame(input logic [7:0] exp, input string name);
    int p0;
    p0 = tx_pulses;
    chk({name, " busy_exec"}, busy, 1);
    chk({name, " no_start_early"}, tx_signal, 0);
    @(posedge clk); #1;
    chk({name, " start"}, tx_signal, 1);
    chk({name, " data"}, tx_data, exp);
    chk({name, " parity"}, tx_parity, ^exp);
    @(posedge clk); #1;
    chk({name, " start_one_cycle"}, tx_signal, 0);
    chk({name, " data_held"}, tx_data, exp);
    chk({name, " busy_wait"}, busy, 1);
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    chk({name, " idle"}, busy, 0);
    chk({name, " one_pulse"}, tx_pulses, p0 + 1);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] exp, input string name);
    send_byte(a, 1'b0);
    send_byte(b, 1'b0);
    send_byte(op, 1'b0);
    finish_frame(exp, name);
  endtask

  initial begin
    int n;
    int p0;
    int e0;

    vecs[0]  = '{8'h05, 8'h03, 8'h20, 8'h08};
    vecs[1]  = '{8'h03, 8'h05, 8'h22, 8'hFE};
    vecs[2]  = '{8'h80, 8'h02, 8'h03, 8'hE0};
    vecs[3]  = '{8'h80, 8'h09, 8'h02, 8'h00};
    vecs[4]  = '{8'hF0, 8'h3C, 8'h24, 8'h30};
    vecs[5]  = '{8'hF0, 8'h0C, 8'h25, 8'hFC};
    vecs[6]  = '{8'hFF, 8'h0F, 8'h26, 8'hF0};
    vecs[7]  = '{8'h0F, 8'hF0, 8'h27, 8'h00};
    vecs[8]  = '{8'h80, 8'h08, 8'h03, 8'hFF};
    vecs[9]  = '{8'h80, 8'h03, 8'h02, 8'h10};
    vecs[10] = '{8'hFF, 8'h02, 8'h20, 8'h01};
    vecs[11] = '{8'h10, 8'h20, 8'hE0, 8'h30};
    vecs[12] = '{8'h40, 8'h02, 8'h03, 8'h10};
    vecs[13] = '{8'h12, 8'h34, 8'h01, 8'h00};

    rst = 1'b1; rx_done = 1'b0; rx_data = '0; rx_parity = 1'b0; tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst tx_signal", tx_signal, 0);
    chk("rst tx_data", tx_data, 0);
    chk("rst tx_parity", tx_parity, 0);
    chk("rst busy", busy, 0);
    chk("rst error", error, 0);
    chk("rst error_code", error_code, 0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, $sformatf("vec%0d", i));
    end
    chk("no_errors_good_frames", err_pulses, 0);

    // Bad parity on operand B drops the frame.
    p0 = tx_pulses;
    send_byte(8'h05, 1'b0);
    send_byte(8'h03, 1'b1);
    chk("par error", error, 1);
    chk("par code", error_code, 2'b01);
    chk("par busy", busy, 0);
    @(posedge clk); #1;
    chk("par error_pulse", error, 0);
    chk("par code_held", error_code, 2'b01);
    chk("par no_start", tx_pulses, p0);
    run_frame(8'h0F, 8'hF0, 8'h27, 8'h00, "after_par");
    chk("par code_held2", error_code, 2'b01);

    // Timeout: only operand A, then silence.
    e0 = err_pulses;
    send_byte(8'h11, 1'b0);
    n = 0;
    while (!error && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tmo cycles", n, 100);
    chk("tmo code", error_code, 2'b10);
    chk("tmo busy", busy, 0);
    chk("tmo one_error", err_pulses, e0);
    run_frame(8'h07, 8'h01, 8'h22, 8'h06, "after_tmo");

    // Unknown opcode; bytes during WAIT_DONE ignored, including a held level.
    p0 = tx_pulses;
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h3F, 1'b0);
    @(posedge clk); #1;
    chk("unk start", tx_signal, 1);
    chk("unk data", tx_data, 8'h00);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    chk("wd busy", busy, 1);
    rx_data = 8'h01; rx_parity = 1'b1; rx_done = 1'b1;
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    chk("wd done_idle", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("wd held_ignored", busy, 0);
    rx_done = 1'b0;
    chk("wd one_pulse", tx_pulses, p0 + 1);
    run_frame(8'h09, 8'h04, 8'h22, 8'h05, "after_wd");

    // Reset while waiting for the opcode.
    p0 = tx_pulses;
    send_byte(8'h05, 1'b0);
    send_byte(8'h03, 1'b0);
    rst = 1'b1;
    #1;
    chk("rstop busy", busy, 0);
    chk("rstop tx_data", tx_data, 0);
    chk("rstop tx_parity", tx_parity, 0);
    chk("rstop code", error_code, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_byte(8'h20, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("rstop no_start", tx_pulses, p0);
    chk("rstop new_frame_busy", busy, 1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h22, 1'b0);
    finish_frame(8'h1F, "rstop_fresh");

    // Reset while waiting for transmit completion.
    send_byte(8'h05, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h20, 1'b0);
    @(posedge clk); #1;
    chk("rstwd start", tx_signal, 1);
    @(posedge clk); #1;
    p0 = tx_pulses;
    chk("rstwd busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("rstwd busy", busy, 0);
    chk("rstwd tx_data", tx_data, 0);
    chk("rstwd tx_parity", tx_parity, 0);
    chk("rstwd tx_signal", tx_signal, 0);
    chk("rstwd error", error, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rstwd no_start", tx_pulses, p0);
    chk("rstwd idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
